// File: rtl/ball_ctrl.sv
// Pong ball motion controller: advances the ball centre once per frame,
// bounces off walls and paddles, detects misses and runs the serve delay.
module ball_ctrl #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BALL_SIZE    = 10,
   parameter int PADDLE_W     = 10,
   parameter int PADDLE_H     = 60,
   parameter int PADDLE_LX    = 20,
   parameter int PADDLE_RX    = 620,
   parameter int SPEED        = 2,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic [8:0] pad_l_y,
   input  logic [8:0] pad_r_y,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic       dx_pos,
   output logic       dy_pos,
   output logic       serving,
   output logic       score_l,
   output logic       score_r
);

   localparam int HALF = BALL_SIZE >> 1;
   localparam int CW   = $clog2(SERVE_FRAMES + 1);

   localparam logic signed [10:0] SPD    = 11'(SPEED);
   localparam logic signed [10:0] TOP    = 11'(HALF);
   localparam logic signed [10:0] BOTTOM = 11'(V_ACTIVE - 1 - HALF);
   localparam logic signed [10:0] LEFT   = 11'(HALF);
   localparam logic signed [10:0] RIGHT  = 11'(H_ACTIVE - 1 - HALF);
   localparam logic signed [10:0] LC     = 11'(PADDLE_LX + PADDLE_W / 2 + HALF);
   localparam logic signed [10:0] RC     = 11'(PADDLE_RX - PADDLE_W / 2 - HALF);
   localparam logic signed [10:0] REACH  = 11'(PADDLE_H / 2 + HALF);
   localparam logic [CW-1:0]      LAST   = CW'(SERVE_FRAMES - 1);

   typedef enum logic {SERVE, PLAY} state_t;

   state_t            state_reg;
   logic [CW-1:0]     serve_cnt_reg;

   logic signed [10:0] cx, cy, nx, ny, pl, pr, dl, dr, adl, adr;
   logic signed [10:0] x_next, y_next;
   logic               dx_next, dy_next;
   logic               hit_l, hit_r, miss_l, miss_r;

   always_comb begin
      cx  = {1'b0, ball_x};
      cy  = {2'b00, ball_y};
      pl  = {2'b00, pad_l_y};
      pr  = {2'b00, pad_r_y};
      nx  = dx_pos ? cx + SPD : cx - SPD;
      ny  = dy_pos ? cy + SPD : cy - SPD;
      dl  = cy - pl;
      dr  = cy - pr;
      adl = dl[10] ? -dl : dl;
      adr = dr[10] ? -dr : dr;

      hit_l  = !dx_pos && (cx >= LC) && (nx <= LC) && (adl < REACH);
      hit_r  =  dx_pos && (cx <= RC) && (nx >= RC) && (adr < REACH);
      miss_r = !hit_l && !hit_r && (nx <= LEFT);
      miss_l = !hit_l && !hit_r && !miss_r && (nx >= RIGHT);

      x_next  = nx;
      dx_next = dx_pos;
      if (hit_l) begin
         x_next  = LC;
         dx_next = 1'b1;
      end else if (hit_r) begin
         x_next  = RC;
         dx_next = 1'b0;
      end

      y_next  = ny;
      dy_next = dy_pos;
      if (!dy_pos && ny <= TOP) begin
         y_next  = TOP;
         dy_next = 1'b1;
      end else if (dy_pos && ny >= BOTTOM) begin
         y_next  = BOTTOM;
         dy_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= SERVE;
         serve_cnt_reg <= '0;
         ball_x        <= 10'(H_ACTIVE / 2);
         ball_y        <= 9'(V_ACTIVE / 2);
         dx_pos        <= 1'b1;
         dy_pos        <= 1'b1;
         serving       <= 1'b1;
         score_l       <= 1'b0;
         score_r       <= 1'b0;
      end else begin
         score_l <= 1'b0;
         score_r <= 1'b0;
         if (frame_tick) begin
            case (state_reg)
               SERVE: begin
                  if (serve_cnt_reg == LAST) begin
                     state_reg     <= PLAY;
                     serve_cnt_reg <= '0;
                     serving       <= 1'b0;
                  end else begin
                     serve_cnt_reg <= serve_cnt_reg + 1'b1;
                  end
               end
               PLAY: begin
                  // A miss recentres the ball and serves toward the conceding side.
                  if (miss_l || miss_r) begin
                     score_l       <= miss_l;
                     score_r       <= miss_r;
                     ball_x        <= 10'(H_ACTIVE / 2);
                     ball_y        <= 9'(V_ACTIVE / 2);
                     dx_pos        <= miss_l;
                     state_reg     <= SERVE;
                     serve_cnt_reg <= '0;
                     serving       <= 1'b1;
                  end else begin
                     ball_x <= x_next[9:0];
                     dx_pos <= dx_next;
                     ball_y <= y_next[8:0];
                     dy_pos <= dy_next;
                  end
               end
               default: state_reg <= SERVE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_ctrl.sv
// Randomized bench for ball_ctrl: a frame-level game model predicts every
// cycle's outputs into a queue that a separate monitor drains and compares.
module tb_ball_ctrl;

   localparam int NCYC   = 30000;
   localparam int CX0    = 320;
   localparam int CY0    = 240;
   localparam int TOPY   = 5;
   localparam int BOTY   = 474;
   localparam int LCX    = 30;
   localparam int RCX    = 610;
   localparam int MISSL  = 5;
   localparam int MISSR  = 634;
   localparam int REACH  = 35;
   localparam int SPD    = 2;
   localparam int SFR    = 60;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic [8:0] pad_l_y;
   logic [8:0] pad_r_y;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       dx_pos, dy_pos, serving, score_l, score_r;

   ball_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .pad_l_y    (pad_l_y),
      .pad_r_y    (pad_r_y),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .dx_pos     (dx_pos),
      .dy_pos     (dy_pos),
      .serving    (serving),
      .score_l    (score_l),
      .score_r    (score_r)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit dx;
      bit dy;
      bit srv;
      bit sl;
      bit sr;
   } exp_t;

   exp_t exp_q[$];

   // Game model: position, direction (+1/-1), serve countdown.
   int m_x, m_y, m_vx, m_vy, m_cnt;
   bit m_srv, m_sl, m_sr;
   int n_checks = 0;
   int n_pass   = 0;
   int n_hits   = 0;
   int n_scores = 0;
   int n_plays  = 0;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int clamp9(input int v);
      if (v < 0) return 0;
      if (v > 479) return 479;
      return v;
   endfunction

   task automatic model_reset();
      m_x = CX0; m_y = CY0; m_vx = 1; m_vy = 1;
      m_srv = 1'b1; m_cnt = 0; m_sl = 1'b0; m_sr = 1'b0;
   endtask

   task automatic model_frame(input int pl, input int pr);
      int nx, ny, wy, wvy;
      m_sl = 1'b0;
      m_sr = 1'b0;
      if (m_srv) begin
         m_cnt = m_cnt + 1;
         if (m_cnt == SFR) begin
            m_srv = 1'b0;
            m_cnt = 0;
            n_plays++;
         end
         return;
      end
      nx  = m_x + SPD * m_vx;
      ny  = m_y + SPD * m_vy;
      wy  = ny;
      wvy = m_vy;
      if (m_vy < 0 && ny <= TOPY) begin wy = TOPY; wvy = 1; end
      if (m_vy > 0 && ny >= BOTY) begin wy = BOTY; wvy = -1; end
      if (m_vx < 0 && m_x >= LCX && nx <= LCX && iabs(m_y - pl) < REACH) begin
         m_x = LCX; m_vx = 1; m_y = wy; m_vy = wvy; n_hits++;
      end else if (m_vx > 0 && m_x <= RCX && nx >= RCX && iabs(m_y - pr) < REACH) begin
         m_x = RCX; m_vx = -1; m_y = wy; m_vy = wvy; n_hits++;
      end else if (nx <= MISSL) begin
         m_sr = 1'b1; m_x = CX0; m_y = CY0; m_vx = -1; m_srv = 1'b1; m_cnt = 0; n_scores++;
      end else if (nx >= MISSR) begin
         m_sl = 1'b1; m_x = CX0; m_y = CY0; m_vx = 1; m_srv = 1'b1; m_cnt = 0; n_scores++;
      end else begin
         m_x = nx; m_y = wy; m_vy = wvy;
      end
   endtask

   task automatic push_expect();
      exp_t e;
      e.x = m_x; e.y = m_y; e.dx = (m_vx > 0); e.dy = (m_vy > 0);
      e.srv = m_srv; e.sl = m_sl; e.sr = m_sr;
      exp_q.push_back(e);
   endtask

   // Paddle choice biased toward the reach boundary around the ball.
   function automatic int pick_pad();
      int offs[11] = '{0, 10, -10, 20, -20, 34, -34, 35, -35, 36, -36};
      if ($urandom_range(0, 9) < 7)
         return clamp9(m_y + offs[$urandom_range(0, 10)]);
      return $urandom_range(0, 479);
   endfunction

   // Driver: sets inputs for the next edge and predicts its result.
   initial begin
      rst_n = 1'b0; frame_tick = 1'b1; pad_l_y = 9'd240; pad_r_y = 9'd240;
      model_reset();
      push_expect();
      repeat (NCYC) begin
         @(negedge clk);
         rst_n      = ($urandom_range(0, 799) != 0);
         frame_tick = ($urandom_range(0, 2) != 0);
         pad_l_y    = 9'(pick_pad());
         pad_r_y    = 9'(pick_pad());
         if (!rst_n) model_reset();
         else if (frame_tick) model_frame(int'(pad_l_y), int'(pad_r_y));
         else begin m_sl = 1'b0; m_sr = 1'b0; end
         push_expect();
      end
   end

   // Monitor: one expected entry per edge, sampled just after it.
   initial begin
      exp_t e;
      repeat (NCYC + 1) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL queue: no expectation at t=%0t (got empty, need entry)", $time);
         end else begin
            e = exp_q.pop_front();
            if (int'(ball_x) == e.x && int'(ball_y) == e.y && dx_pos == e.dx &&
                dy_pos == e.dy && serving == e.srv && score_l == e.sl && score_r == e.sr)
               n_pass++;
            else
               $display("FAIL state t=%0t: got x=%0d y=%0d dx=%0b dy=%0b srv=%0b sl=%0b sr=%0b need x=%0d y=%0d dx=%0b dy=%0b srv=%0b sl=%0b sr=%0b",
                        $time, ball_x, ball_y, dx_pos, dy_pos, serving, score_l, score_r,
                        e.x, e.y, e.dx, e.dy, e.srv, e.sl, e.sr);
         end
         if (!serving) begin
            n_checks++;
            if (ball_x >= 10'd6 && ball_x <= 10'd633 && ball_y >= 9'd5 && ball_y <= 9'd474)
               n_pass++;
            else
               $display("FAIL range t=%0t: got (%0d,%0d) need x 6..633 y 5..474", $time, ball_x, ball_y);
         end
         n_checks++;
         if (!(score_l && score_r))
            n_pass++;
         else
            $display("FAIL scores t=%0t: got both pulses high, need at most one", $time);
      end
      $display("info: paddle hits=%0d scores=%0d serves completed=%0d", n_hits, n_scores, n_plays);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Frame-rate motion controller for the pong ball sprite.
- Holds ball centre position and direction, and advances it once per video frame.
- Handles bounces off the top/bottom walls and both paddles, detects misses, emits score pulses and runs the serve delay.
- Outputs drive the ball sprite's centre inputs directly; paddle centres come from the paddle input logic.

Parameters:
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
BALL_SIZE, 10, ball width/height in pixels; HALF = BALL_SIZE>>1
PADDLE_W, 10, paddle width
PADDLE_H, 60, paddle height
PADDLE_LX, 20, left paddle centre x
PADDLE_RX, 620, right paddle centre x
SPEED, 2, pixels moved per frame on each axis
SERVE_FRAMES, 60, frames the ball is held at centre before play

Ports:
clk  input  1  pixel clock
rst_n  input  1  synchronous active-low reset
frame_tick  input  1  one-cycle pulse, once per frame at start of vertical blank
pad_l_y  input  9  left paddle centre y
pad_r_y  input  9  right paddle centre y
ball_x  output  10  ball centre x (registered)
ball_y  output  9  ball centre y (registered)
dx_pos  output  1  1 = moving right
dy_pos  output  1  1 = moving down
serving  output  1  1 while in SERVE state
score_l  output  1  one-cycle pulse: left player scored
score_r  output  1  one-cycle pulse: right player scored

Behaviour:
- Reset (rst_n low at a clk edge):
  - ball_x=H_ACTIVE/2 (320), ball_y=V_ACTIVE/2 (240), dx_pos=1, dy_pos=1.
  - State SERVE, serve counter=0, serving=1, score_l=score_r=0.
  - Reset overrides frame_tick in the same cycle, including mid-play.
- State only changes on a clk edge where frame_tick=1. All outputs are registered, so new values appear the cycle after the tick is sampled. With frame_tick low, the block holds all state.
- SERVE:
  - Each tick increments the counter.
  - On the tick where counter==SERVE_FRAMES-1: go to PLAY, clear counter, serving=0. Position is not moved on that tick.
- PLAY, per tick:
  - Compute nx = ball_x ± SPEED and ny = ball_y ± SPEED in 11-bit signed arithmetic, so there is no unsigned wrap.
  - Y axis:
    - Moving up with ny <= HALF: ball_y=HALF, dy_pos=1.
    - Moving down with ny >= V_ACTIVE-1-HALF (474): ball_y=474, dy_pos=0.
    - Otherwise ball_y=ny.
  - X axis, left contact LC = PADDLE_LX+PADDLE_W/2+HALF (30):
    - Left paddle hit when moving left, ball_x >= LC, nx <= LC, and |ball_y - pad_l_y| < PADDLE_H/2+HALF (35). Result: ball_x=LC, dx_pos=1.
  - X axis, right contact RC = PADDLE_RX-PADDLE_W/2-HALF (610):
    - Right paddle hit mirrors the left: moving right, ball_x <= RC, nx >= RC, |ball_y - pad_r_y| < 35. Result: ball_x=RC, dx_pos=0.
  - Misses:
    - nx <= HALF (5): right player scores.
    - nx >= H_ACTIVE-1-HALF (634): left player scores.
  - Otherwise ball_x=nx.
  - A wall bounce and a paddle bounce on the same tick both apply (corner case).
- On a miss, within the same tick:
  - Pulse score_r or score_l high for exactly one cycle.
  - Ball returns to (320,240); the Y update is discarded.
  - dx_pos points toward the player who conceded (left miss gives dx_pos=0). dy_pos is kept.
  - State goes to SERVE with counter=0 and serving=1.
- score_l and score_r are never high together, and never high for more than one cycle.
- ball_y must stay within 5..474 while in PLAY. ball_x must stay within 6..633 while in PLAY.

Test Plan:
1. Reset, then 60 frame_ticks → serving drops after the 60th tick with ball still at (320,240). The 61st tick gives (322,242).
2. PLAY, ball (200,6), dy_pos=0, tick → ball_y=5, dy_pos=1, ball_x=198. Next tick → ball_y=7.
3. PLAY, ball (31,240), dx_pos=0, pad_l_y=240, tick → ball_x=30, dx_pos=1. Repeat with pad_l_y=206 (diff 34) → hit. Repeat with pad_l_y=205 (diff 35) → no hit, ball_x=29.
4. PLAY, ball (7,240), dx_pos=0, pad_l_y=100, tick → score_r high for one cycle, ball (320,240), dx_pos=0, serving=1. Holding frame_tick low keeps score_r low afterwards.
5. PLAY, ball (608,473), moving right/down, pad_r_y=450, tick → ball_x=610, dx_pos=0, ball_y=474, dy_pos=0 (simultaneous bounce).
6. rst_n low mid-SERVE (counter 30) coincident with frame_tick → all reset values; the next 60 ticks are required before play.
